// File: rtl/flop_pipe_sync.sv
// -----------------------------------------------------------------------------
// flop_pipe_sync
//   DEPTH-stage, WIDTH-bit elastic register pipeline. Each stage has its own
//   valid bit. Bubbles collapse: a stage refills as soon as it empties or its
//   contents move on. valid/ready backpressure, synchronous flush, a
//   programmable reset value and a registered occupancy count.
//
// Ports
//   clk        rising-edge clock (only clock)
//   reset      synchronous, active-high reset (priority over flush)
//   flush      synchronous clear of all stages; input handshake is dropped
//   in_valid   upstream word valid
//   in_data    upstream word
//   in_ready   pipeline accepts in_data this cycle
//   out_valid  last stage holds a valid word
//   out_data   word in last stage
//   out_ready  downstream takes out_data this cycle
//   count      number of valid stages, 0..DEPTH
// -----------------------------------------------------------------------------
module flop_pipe_sync #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] take;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic             accept;
  logic             emit;

  // Ready chain, evaluated from the output stage back to the input stage. A
  // stage can take a word if it is empty or its own word moves on this edge,
  // so a full pipe still shifts as a whole when out_ready is high.
  // NOTE: every variable gets a default before the loop so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    adv            = '0;
    take           = '0;
    adv[DEPTH-1]   = v[DEPTH-1] & out_ready;
    take[DEPTH-1]  = !v[DEPTH-1] | adv[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i]  = v[i] & take[i+1];
      take[i] = !v[i] | adv[i];
    end
  end

  assign in_ready  = take[0];
  assign accept    = in_valid & take[0];
  assign emit      = adv[DEPTH-1];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  // NOTE: all sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the shift happens in lockstep.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      v     <= '0;
      count <= '0;
      // NOTE: the data stages are reset deliberately: RESET_VAL is visible
      // on out_data after reset/flush, so this storage is not don't-care.
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RESET_VAL;
      end
    end else begin
      if (accept) begin
        d[0] <= in_data;
        v[0] <= 1'b1;
      end else if (adv[0]) begin
        v[0] <= 1'b0;
      end

      // Data of a stage that empties is left as-is; only its valid drops.
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i-1]) begin
          d[i] <= d[i-1];
          v[i] <= 1'b1;
        end else if (adv[i]) begin
          v[i] <= 1'b0;
        end
      end

      // Accept and emit on the same edge cancel out.
      case ({accept, emit})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_flop_pipe_sync.sv
// -----------------------------------------------------------------------------
// tb_flop_pipe_sync
//   Directed vectors for reset, latency, backpressure, bubble collapse and
//   flush, then a random valid/ready soak. A scoreboard queue collects every
//   accepted word; a negedge monitor pops and compares whenever a word leaves,
//   tracks occupancy against count and checks out_data stability while stalled.
// -----------------------------------------------------------------------------
module tb_flop_pipe_sync;

  localparam int          WIDTH     = 8;
  localparam int          DEPTH     = 3;
  localparam logic [7:0]  RESET_VAL = 8'hA5;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [1:0] count;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  bit          mon_en     = 1'b0;

  logic [7:0] sb_q [$];

  flop_pipe_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RESET_VAL)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after each rising edge; registered outputs are
  // settled by then, so directed checks are made right after tick().
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] id, input logic ordy);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'(RESET_VAL));
    check({tag, "_count"},     32'(count),     32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  // Scoreboard monitor: inputs are stable mid-cycle, so the handshakes that
  // will occur on the coming edge are known at the falling edge.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;

  always @(negedge clk) begin
    if (mon_en) begin
      check("count_vs_occupancy", 32'(count), 32'(sb_q.size()));
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data",  32'(out_data),  32'(prev_data));
      end
      if (reset || flush) begin
        sb_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          check("sb_word_expected", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) check("sb_out_data", 32'(out_data), 32'(sb_q.pop_front()));
        end
        if (in_valid && in_ready) sb_q.push_back(in_data);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    mon_en = 1'b1;
    check_reset_state("init_reset");
    reset = 1'b0;

    // Streaming: 01 appears two edges after its accept edge, then one per cycle.
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 8'(k), 1'b1);
      tick();
      if (k == 1) check("lat_edge_n",  32'(out_valid), 32'd0);
      if (k == 2) check("lat_edge_n1", 32'(out_valid), 32'd0);
      if (k == 3) begin
        check("lat_edge_n2_valid", 32'(out_valid), 32'd1);
        check("lat_edge_n2_data",  32'(out_data),  32'h01);
      end
      if (k >= 3) check("stream_count", 32'(count), 32'd3);
    end
    drive(1'b0, 8'h00, 1'b1);
    repeat (4) tick();
    check("stream_drained", 32'(count), 32'd0);

    // Mid-stream reset held for two cycles.
    drive(1'b1, 8'h30, 1'b1);
    tick();
    drive(1'b1, 8'h31, 1'b1);
    tick();
    reset = 1'b1;
    drive(1'b1, 8'h32, 1'b0);
    tick();
    tick();
    check_reset_state("mid_reset");
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    tick();

    // Backpressure fill.
    drive(1'b1, 8'h10, 1'b0); tick();
    drive(1'b1, 8'h11, 1'b0); tick();
    drive(1'b1, 8'h12, 1'b0); tick();
    drive(1'b1, 8'h13, 1'b0);
    #1;
    check("full_in_ready", 32'(in_ready),  32'd0);
    check("full_count",    32'(count),     32'd3);
    check("full_out_data", 32'(out_data),  32'h10);
    tick();
    check("stalled_count", 32'(count),    32'd3);
    check("stalled_data",  32'(out_data), 32'h10);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("release_count", 32'(count),    32'd3);
    check("release_data",  32'(out_data), 32'h11);
    drive(1'b0, 8'h00, 1'b1);
    repeat (4) tick();
    check("bp_drained", 32'(count), 32'd0);

    // Bubble collapse: 20 and 21 pack into stages 2 and 1.
    drive(1'b1, 8'h20, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
    tick();
    drive(1'b1, 8'h21, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
    check("bubble_count",     32'(count),     32'd2);
    check("bubble_in_ready",  32'(in_ready),  32'd1);
    check("bubble_out_data",  32'(out_data),  32'h20);
    check("bubble_out_valid", 32'(out_valid), 32'd1);

    // Flush with a pending input; 55 must never appear.
    drive(1'b1, 8'h22, 1'b0); tick();
    check("preflush_count", 32'(count), 32'd3);
    flush = 1'b1;
    drive(1'b1, 8'h55, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    check("flush_count",     32'(count),     32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_data",  32'(out_data),  32'(RESET_VAL));
    repeat (4) begin
      tick();
      check("postflush_idle", 32'(out_valid), 32'd0);
    end

    // Random soak.
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      tick();
    end

    // Drain with a bounded budget.
    drive(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 20 && sb_q.size() != 0; c++) tick();
    tick();
    check("final_drained", 32'(sb_q.size()), 32'd0);
    check("final_count",   32'(count),       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flop_pipe_sync.md
Name: flop_pipe_sync

Overview:
- Parametrised successor to the single-bit synchronous-reset flop.
- A DEPTH-stage, WIDTH-bit register pipeline with per-stage valid bits and valid/ready backpressure.
- Empty stages collapse (bubbles are squeezed out). Has a synchronous flush, a programmable reset value and an occupancy count.
- Used as the standard retiming/elastic stage between datapath blocks.

Parameters:
- WIDTH, 8: data bits per stage; must be at least 1.
- DEPTH, 3: number of register stages; must be at least 1.
- RESET_VAL, 0: WIDTH-bit value loaded into every data stage on reset or flush.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of the pipeline contents.
- in_valid  input  1  upstream data valid.
- in_data  input  WIDTH  upstream data.
- in_ready  output  1  pipeline can accept in_data this cycle.
- out_valid  output  1  stage DEPTH-1 holds valid data.
- out_data  output  WIDTH  data in stage DEPTH-1.
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Clocking and reset:
  - Single clock domain. All state updates on the rising edge of clk.
  - reset is sampled only at the edge (synchronous, active-high).
- Per-stage state: valid bit v[i] and data d[i], for i = 0..DEPTH-1. Stage 0 is the input stage.
- Reset:
  - All v[i] = 0 and all d[i] = RESET_VAL.
  - Outputs after the reset edge: out_valid = 0, out_data = RESET_VAL, count = 0, in_ready = 1.
- Flush:
  - Same effect as reset, one edge.
  - Any input handshake in the flush cycle is discarded.
  - reset has priority over flush.
- Move and handshake rules:
  - Advance term: adv[DEPTH-1] = v[DEPTH-1] & out_ready.
  - Stage i can take new data when take[i] = !v[i] | adv[i].
  - For i < DEPTH-1: adv[i] = v[i] & take[i+1].
  - in_ready = take[0].
  - The ready chain is combinational from out_ready to in_ready; this path is intended.
- Per-edge update, when neither reset nor flush is asserted:
  - Stage 0: if in_valid & in_ready, then d[0] <= in_data and v[0] <= 1. Otherwise, if adv[0], then v[0] <= 0.
  - Stage i > 0: if adv[i-1], then d[i] <= d[i-1] and v[i] <= 1. Otherwise, if adv[i], then v[i] <= 0.
  - Data of invalid stages holds its last value; it is not cleared.
- Latency:
  - Empty pipe, out_ready = 1: in_data accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1.
  - Steady-state throughput is 1 word per cycle.
- Backpressure:
  - out_ready = 0 with out_valid = 1 freezes stage DEPTH-1.
  - Upstream stages keep filling until full. Full means all v = 1; then in_ready = 0.
  - When out_ready rises, all stages shift on the same edge, so a full pipe accepts a new word on that edge.
- Order and integrity: data order is preserved; no word is duplicated or dropped, except on reset or flush.
- count:
  - Registered. It equals the population of v after each edge.
  - It increments on accept-only edges and decrements on output-only edges.
  - It is unchanged when an input is accepted and an output is taken on the same edge.
  - Bounded 0..DEPTH.
- Protocol rule: out_data is stable while out_valid = 1 and out_ready = 0.
- Degenerate case: DEPTH = 1 behaves as a single valid/ready register. in_ready = !v[0] | out_ready.

Test Plan:
- Reset: WIDTH=8, DEPTH=3, RESET_VAL=8'hA5. Assert reset for 2 cycles mid-stream -> out_valid=0, out_data=8'hA5, count=0, in_ready=1 after the edge.
- Streaming: out_ready=1 held high; feed 8'h01..8'h0A on consecutive cycles -> 8'h01 appears 2 edges after its accept edge; then one word per cycle, in order; count stays 3.
- Backpressure/fill: out_ready=0; feed 8'h10,8'h11,8'h12,8'h13:
  - 8'h13 is stalled; in_ready=0 after the 3rd accept; count=3; out_data stays 8'h10.
  - Raise out_ready -> 8'h13 is accepted on that edge; output sequence is 8'h10,11,12,13.
- Bubble collapse: feed 8'h20, idle 2 cycles, feed 8'h21, with out_ready=0:
  - Both words pack into stages 2 and 1; count=2; in_ready=1.
- Flush: with count=3, assert flush together with in_valid=1, in_data=8'h55 -> next cycle count=0, out_valid=0; 8'h55 is never output.
- Random: random in_valid and out_ready for 10k cycles -> a scoreboard matches in/out order exactly; count equals occupancy and stays 0..3; out_data is stable while stalled.
